// File: rtl/dht_reader.sv
// Single-wire DHT11/DHT22 temperature/humidity reader.
// Durations are counted in microsecond ticks; the timers restart on every state change.
module dht_reader #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DHT22      = 0,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_US = 200,
  parameter int THRESH_US  = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data_in,
  output logic        data_oe,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        valid,
  output logic        busy,
  output logic        sample_done,
  output logic        err_timeout,
  output logic        err_checksum
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_LOW = 3'd1;
  localparam logic [2:0] RELEASE   = 3'd2;
  localparam logic [2:0] RESP_LOW  = 3'd3;
  localparam logic [2:0] RESP_HIGH = 3'd4;
  localparam logic [2:0] BIT_LOW   = 3'd5;
  localparam logic [2:0] BIT_HIGH  = 3'd6;
  localparam logic [2:0] CHECK     = 3'd7;

  localparam int     DIV      = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int     PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int     START_US = (DHT22 != 0) ? 1000 : 18000;
  localparam int     UMAX     = (START_US > TIMEOUT_US) ? START_US : TIMEOUT_US;
  localparam int     UW       = $clog2(UMAX + 1);
  localparam longint PCYC     = (PERIOD_MS > 0) ? longint'(PERIOD_MS) * (CLK_HZ / 1000) : 1;
  localparam int     TW       = $clog2(PCYC + 1);

  logic [1:0]    sync;
  logic          line, line_d, rise, fall;
  logic [2:0]    state, state_nxt;
  logic [PW-1:0] pre;
  logic          tick, tmo, go, done_now;
  logic [UW-1:0] us_cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic [TW-1:0] per_cnt;
  logic          auto_due;
  logic [7:0]    sum;

  assign line     = sync[1];
  assign rise     = line & ~line_d;
  assign fall     = ~line & line_d;
  assign tick     = (pre == PW'(DIV - 1));
  assign tmo      = tick && (us_cnt == UW'(TIMEOUT_US - 1));
  assign auto_due = (PERIOD_MS > 0) && (per_cnt == TW'(PCYC - 1));
  assign go       = start | auto_due;
  assign sum      = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign busy     = (state != IDLE);
  assign done_now = (state != IDLE) && (state_nxt == IDLE);

  // Sensor-driven phases advance on a synchronized edge; an edge wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (go) state_nxt = START_LOW;
      START_LOW: if (tick && us_cnt == UW'(START_US - 1)) state_nxt = RELEASE;
      RELEASE:   if (fall) state_nxt = RESP_LOW;  else if (tmo) state_nxt = IDLE;
      RESP_LOW:  if (rise) state_nxt = RESP_HIGH; else if (tmo) state_nxt = IDLE;
      RESP_HIGH: if (fall) state_nxt = BIT_LOW;   else if (tmo) state_nxt = IDLE;
      BIT_LOW:   if (rise) state_nxt = BIT_HIGH;  else if (tmo) state_nxt = IDLE;
      BIT_HIGH:  if (fall) state_nxt = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                 else if (tmo) state_nxt = IDLE;
      CHECK:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync         <= '0;
      line_d       <= 1'b0;
      state        <= IDLE;
      pre          <= '0;
      us_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      per_cnt      <= '0;
      data_oe      <= 1'b0;
      humidity     <= '0;
      temperature  <= '0;
      valid        <= 1'b0;
      sample_done  <= 1'b0;
      err_timeout  <= 1'b0;
      err_checksum <= 1'b0;
    end else begin
      sync        <= {sync[0], data_in};
      line_d      <= line;
      state       <= state_nxt;
      data_oe     <= (state_nxt == START_LOW);
      sample_done <= done_now;

      if (state_nxt != state) begin
        pre    <= '0;
        us_cnt <= '0;
      end else if (tick) begin
        pre    <= '0;
        us_cnt <= us_cnt + 1'b1;
      end else begin
        pre    <= pre + 1'b1;
      end

      // Auto-sample timer saturates at expiry and restarts with each completed transaction.
      if (done_now)       per_cnt <= '0;
      else if (!auto_due) per_cnt <= per_cnt + 1'b1;

      if (state == IDLE && go) begin
        err_timeout  <= 1'b0;
        err_checksum <= 1'b0;
        bit_cnt      <= '0;
      end

      if (done_now && state != CHECK) err_timeout <= 1'b1;

      if (state == BIT_HIGH && fall) begin
        shreg   <= {shreg[38:0], (int'(us_cnt) > THRESH_US)};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == CHECK) begin
        if (sum == shreg[7:0]) begin
          humidity    <= shreg[39:24];
          temperature <= shreg[23:8];
          valid       <= 1'b1;
        end else begin
          err_checksum <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dht_reader.sv
// Bench for dht_reader: DHT11 no-response timeout, DHT22 frames from a sensor model,
// and auto-sampling with a coincident start request.
`timescale 1ns/1ps
module tb_dht_reader;
  logic clk = 1'b0;
  always #250 clk = ~clk;  // 2 MHz

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst, st, sdrv, oe, vld, bsy, done, eto, eck;
  logic [15:0] hum [3];
  logic [15:0] tmp [3];

  dht_reader #(.CLK_HZ(2_000_000), .DHT22(0), .PERIOD_MS(0)) u0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .data_in(~oe[0] & sdrv[0]), .data_oe(oe[0]),
    .humidity(hum[0]), .temperature(tmp[0]), .valid(vld[0]), .busy(bsy[0]),
    .sample_done(done[0]), .err_timeout(eto[0]), .err_checksum(eck[0]));
  dht_reader #(.CLK_HZ(2_000_000), .DHT22(1), .PERIOD_MS(0)) u1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .data_in(~oe[1] & sdrv[1]), .data_oe(oe[1]),
    .humidity(hum[1]), .temperature(tmp[1]), .valid(vld[1]), .busy(bsy[1]),
    .sample_done(done[1]), .err_timeout(eto[1]), .err_checksum(eck[1]));
  dht_reader #(.CLK_HZ(2_000_000), .DHT22(1), .PERIOD_MS(1)) u2 (
    .clk(clk), .reset(rst[2]), .start(st[2]), .data_in(~oe[2] & sdrv[2]), .data_oe(oe[2]),
    .humidity(hum[2]), .temperature(tmp[2]), .valid(vld[2]), .busy(bsy[2]),
    .sample_done(done[2]), .err_timeout(eto[2]), .err_checksum(eck[2]));

  int n_vec = 0, n_bad = 0;
  int done_cnt [3] = '{default: 0};
  int rise_cnt [3] = '{default: 0};
  logic [2:0] oe_q = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      if (oe[i] === 1'b1 && oe_q[i] !== 1'b1) rise_cnt[i] <= rise_cnt[i] + 1;
    end
    oe_q <= oe;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  // Sensor reply: response low/high, then nbits data bits MSB first.
  // A full frame leaves the line low after the last bit; the caller releases it.
  task automatic sensor(input int i, input logic [39:0] fr, input int nbits);
    wait_us(20); sdrv[i] = 1'b0; wait_us(80); sdrv[i] = 1'b1; wait_us(80);
    for (int b = 39; b >= 40 - nbits; b--) begin
      sdrv[i] = 1'b0; wait_us(20);
      sdrv[i] = 1'b1; wait_us(fr[b] ? 70 : 26);
    end
    if (nbits == 40) sdrv[i] = 1'b0;
  endtask

  function automatic logic [39:0] mkframe(input bit good);
    logic [7:0] b0, b1, b2, b3, ck;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    ck = b0 + b1 + b2 + b3;
    if (!good) ck = ck ^ 8'($urandom_range(1, 255));
    return {b0, b1, b2, b3, ck};
  endfunction

  // Reference state of the DHT22 instance.
  logic [15:0] eh = '0, et = '0;
  logic        ev = 1'b0;

  task automatic xact(input logic [39:0] fr, input int nbits);
    int n, d0, tr, tf, s;
    bit good;
    d0 = done_cnt[1];
    st[1] = 1'b1; @(negedge clk); st[1] = 1'b0;
    n = 0; while (oe[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("oe_rise", oe[1], 1'b1); tr = cyc;
    chk("busy_start", bsy[1], 1'b1);
    st[1] = 1'b1; @(negedge clk); st[1] = 1'b0;  // must be ignored
    n = 0; while (oe[1] !== 1'b0 && n < 2100) begin @(negedge clk); n++; end
    chk("oe_fall", oe[1], 1'b0); tf = cyc;
    chk("oe_low_cycles", tf - tr, 2000);
    sensor(1, fr, nbits);
    if (nbits < 40) begin
      rst[1] = 1'b0; #1;
      eh = '0; et = '0; ev = 1'b0;
      chk("rst_oe", oe[1], 1'b0);   chk("rst_busy", bsy[1], 1'b0);
      chk("rst_hum", hum[1], eh);   chk("rst_tmp", tmp[1], et);
      chk("rst_valid", vld[1], ev); chk("rst_done", done[1], 1'b0);
      chk("rst_eto", eto[1], 1'b0); chk("rst_eck", eck[1], 1'b0);
      repeat (10) @(negedge clk);
      chk("rst_no_done", done_cnt[1] - d0, 0);
      rst[1] = 1'b1;
      return;
    end
    n = 0; while (done[1] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("done_seen", done[1], 1'b1);
    sdrv[1] = 1'b1;
    repeat (5) @(negedge clk);
    s = fr[39:32] + fr[31:24] + fr[23:16] + fr[15:8];
    good = ((s % 256) == int'(fr[7:0]));
    if (good) begin eh = fr[39:24]; et = fr[23:8]; ev = 1'b1; end
    chk("done_once", done_cnt[1] - d0, 1);
    chk("hum", hum[1], eh);       chk("tmp", tmp[1], et);
    chk("valid", vld[1], ev);     chk("eck", eck[1], !good);
    chk("eto", eto[1], 1'b0);     chk("busy_end", bsy[1], 1'b0);
    chk("no_restart", rise_cnt[1] > 0 ? oe[1] : 1'b0, 1'b0);
  endtask

  initial begin
    int c0;
    rst = '0; st = '0; sdrv = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_oe", oe[i], 1'b0);     chk("reset_busy", bsy[i], 1'b0);
      chk("reset_hum", hum[i], 16'h0);  chk("reset_tmp", tmp[i], 16'h0);
      chk("reset_valid", vld[i], 1'b0); chk("reset_done", done[i], 1'b0);
      chk("reset_err", {eto[i], eck[i]}, 2'b00);
    end
    rst = '1; c0 = cyc;
    fork
      begin : t_dht11
        int n, tr, tf;
        st[0] = 1'b1; @(negedge clk); st[0] = 1'b0;
        n = 0; while (oe[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("t11_oe_rise", oe[0], 1'b1); tr = cyc;
        n = 0; while (oe[0] !== 1'b0 && n < 36100) begin @(negedge clk); n++; end
        chk("t11_oe_fall", oe[0], 1'b0); tf = cyc;
        chk("t11_low_cycles", tf - tr, 36000);
        chk("t11_busy_release", bsy[0], 1'b1);
        n = 0; while (done[0] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk("t11_done", done[0], 1'b1);
        chk("t11_tmo_delay", cyc - tf, 400);
        chk("t11_eto", eto[0], 1'b1);   chk("t11_eck", eck[0], 1'b0);
        chk("t11_valid", vld[0], 1'b0); @(negedge clk);
        chk("t11_busy_end", bsy[0], 1'b0);
      end
      begin : t_dht22
        xact(40'h3700_1900_50, 40);
        xact(40'h3700_1900_51, 40);
        xact(mkframe(1), 20);
        xact(mkframe(1), 40);
        xact(mkframe($urandom_range(0, 3) != 0), 40);
        xact(mkframe(0), 40);
      end
      begin : t_auto
        int n, tr, td;
        while (cyc != c0 + 1999) @(negedge clk);
        st[2] = 1'b1; @(negedge clk); st[2] = 1'b0;
        n = 0; while (oe[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("auto_first_at", cyc - c0, 2000); tr = cyc;
        n = 0; while (done[2] !== 1'b1 && n < 2600) begin @(negedge clk); n++; end
        chk("auto_done", done[2], 1'b1); td = cyc;
        chk("auto_xact_len", td - tr, 2400);
        chk("auto_one_xact", rise_cnt[2], 1);
        chk("auto_eto", eto[2], 1'b1);
        @(negedge clk);
        chk("auto_one_done", done_cnt[2], 1);
        n = 0; while (oe[2] !== 1'b1 && n < 2100) begin @(negedge clk); n++; end
        chk("auto_next_at", cyc - td, 2000);
        chk("auto_eto_clr", eto[2], 1'b0);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dht_reader.md
DHT_READER -- requirements
Module: dht_reader

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: clk frequency in Hz; a microsecond tick is derived from it as CLK_HZ/1_000_000 cycles.
REQ-002 Parameter DHT22, default 0: 0 selects DHT11 start timing, 1 selects DHT22 start timing.
REQ-003 Parameter PERIOD_MS, default 2000: automatic sample interval in ms; 0 disables auto-sampling.
REQ-004 Parameter TIMEOUT_US, default 200: maximum duration of any sensor-driven phase.
REQ-005 Parameter THRESH_US, default 40: a data-bit high pulse longer than this decodes as 1.
REQ-006 Port clk, input, 1: the single clock.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port start, input, 1: single-cycle request for one measurement.
REQ-009 Port data_in, input, 1: raw sensor line level, asynchronous to clk.
REQ-010 Port data_oe, output, 1: 1 = drive the sensor line low; 0 = release it (tri-state lives in the top level).
REQ-011 Port humidity, output, 16: raw bytes {b0,b1} of the last good frame.
REQ-012 Port temperature, output, 16: raw bytes {b2,b3} of the last good frame.
REQ-013 Port valid, output, 1: at least one good frame has been received since reset.
REQ-014 Port busy, output, 1: a transaction is in progress.
REQ-015 Port sample_done, output, 1: one-cycle pulse at the end of every transaction, good or failed.
REQ-016 Port err_timeout, output, 1: the last transaction failed on timeout.
REQ-017 Port err_checksum, output, 1: the last transaction failed on checksum.

Function
REQ-018 data_in SHALL pass through a 2-flop synchronizer; all edge detection uses the synchronized level.
REQ-019 All durations SHALL be counted in whole microsecond ticks by a counter that is cleared on every state change.
REQ-020 States: IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-021 IDLE: if start=1, or the auto-sample timer expires, go to START_LOW; both in the same cycle produce one transaction.
REQ-022 Entering START_LOW SHALL clear err_timeout and err_checksum.
REQ-023 START_LOW: data_oe=1 for 18000 us (DHT11) or 1000 us (DHT22), then go to RELEASE with data_oe=0.
REQ-024 RELEASE: wait for the line to go low, then go to RESP_LOW.
REQ-025 RESP_LOW: wait for the line to go high, then go to RESP_HIGH.
REQ-026 RESP_HIGH: wait for the line to go low, then go to BIT_LOW.
REQ-027 BIT_LOW: wait for the line to go high, then go to BIT_HIGH.
REQ-028 BIT_HIGH: on the falling edge, shift in bit = (high_us > THRESH_US), MSB first, into a 40-bit register; after bit 40 go to CHECK, otherwise go to BIT_LOW.
REQ-029 If any of RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH exceeds TIMEOUT_US, the block SHALL set err_timeout, pulse sample_done and return to IDLE.
REQ-030 CHECK (1 cycle): if (b0+b1+b2+b3) mod 256 == b4, update humidity and temperature and set valid=1; otherwise set err_checksum and leave the data outputs unchanged. In both cases pulse sample_done and return to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE; start while busy is ignored and not queued.
REQ-032 The auto-sample timer SHALL restart at each sample_done; the first auto sample occurs PERIOD_MS after reset is released.
REQ-033 sample_done SHALL assert exactly one cycle after the decisive edge or the timeout.

Reset
REQ-034 While reset=0: state=IDLE, data_oe=0, humidity=0, temperature=0, valid=0, busy=0, sample_done=0, both error flags=0, and all counters, shift register and synchronizer cleared.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately with data_oe=0 and no sample_done pulse.

Verification (CLK_HZ=2_000_000, PERIOD_MS=0)
REQ-036 start; sensor model sends 0x37,0x00,0x19,0x00,0x50 -> humidity=0x3700, temperature=0x1900, valid=1, one sample_done, no errors.
REQ-037 Same frame with checksum 0x51 -> err_checksum=1, humidity and temperature keep their prior values, sample_done pulses once.
REQ-038 start with no sensor response -> data_oe low for 36000 cycles, then err_timeout=1 400 cycles after release.
REQ-039 DHT22=1 -> data_oe low for exactly 2000 cycles; bit high pulses of 26 us decode as 0 and 70 us decode as 1.
REQ-040 reset=0 during bit 20, then start after release -> outputs zero, the next full frame decodes correctly.
REQ-041 PERIOD_MS=1 with start and the auto tick in the same cycle -> one transaction; the next one starts 1 ms after sample_done.
